hamming74_decoder_pipe: RTL and testbench
=========================================

Name: hamming74_decoder_pipe

Overview:
- Streaming Hamming(7,4) single-error-correcting decoder: the receive side paired with the team's hamming_encoder.
- Accepts 7-bit codewords over a valid/ready handshake and computes the 3-bit syndrome.
- Corrects any single-bit error and emits the 4-bit data word through a 2-stage pipeline with full backpressure.
- Keeps a saturating count of corrected words for link-health monitoring.

Parameters:
- CNT_W, 8, width of the corrected-error counter (saturates at 2^CNT_W-1).

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_code  input  7  received codeword
- in_valid  input  1  in_code is valid this cycle
- in_ready  output  1  decoder can accept in_code this cycle
- out_data  output  4  decoded/corrected data
- out_err  output  1  a single-bit error was corrected in this word
- out_pos  output  3  error position 1..7 (0 = no error)
- out_valid  output  1  out_* are valid
- out_ready  input  1  downstream accepts out_* this cycle
- clr_cnt  input  1  synchronous clear of err_cnt
- err_cnt  output  CNT_W  count of words with out_err=1 accepted downstream

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Bit mapping (must match hamming_encoder):
  - code[7-k] holds Hamming position k: code[6]=p1, code[5]=p2, code[4]=d1, code[3]=p3, code[2]=d2, code[1]=d3, code[0]=d4.
  - Data: d1=data[0], d2=data[1], d3=data[2], d4=data[3].
  - Example: data 4'b1011 <-> code 7'b1010101.
- Syndrome:
  - s1 = XOR of positions 1,3,5,7.
  - s2 = XOR of positions 2,3,6,7.
  - s3 = XOR of positions 4,5,6,7.
  - syn = {s3,s2,s1}, 0..7.
  - syn != 0 means invert bit code[7-syn] before extracting data.
- Stage 1 (S1): on an in_valid && in_ready edge, register in_code, syn and s1_valid=1.
- Stage 2 (S2): on an S1->S2 transfer, register the corrected data, out_err=(syn!=0), out_pos=syn and out_valid=1.
- Pipeline control:
  - S2 frees when !out_valid || out_ready.
  - S1 advances when s1_valid && S2 frees.
  - in_ready = !s1_valid || S1 advances.
  - in_ready is combinational from out_ready; there is no combinational path from in_* to out_*.
- Latency and throughput:
  - Latency is 2 cycles: a word accepted at edge N shows out_valid=1 after edge N+1 with no stall.
  - Throughput is 1 word/cycle when out_ready=1.
- Backpressure:
  - While out_valid && !out_ready, out_* hold stable.
  - S1 holds one more word; in_ready drops once S1 is also occupied.
  - No word is dropped or duplicated.
- Valid-bit clearing: with no new input, s1_valid and out_valid clear on transfer.
- err_cnt:
  - Increments on the out_valid && out_ready && out_err edge; saturates at max and never wraps.
  - clr_cnt=1 forces 0 and has priority over an increment in the same cycle.
- Double-bit errors:
  - These cannot be detected by (7,4).
  - The decoder miscorrects per the syndrome; this is the defined behaviour, not a fault.
- Reset:
  - Values: s1_valid=0, out_valid=0, out_data=0, out_err=0, out_pos=0, err_cnt=0.
  - in_ready=1 once rst deasserts.
  - Reset mid-stream discards all in-flight words immediately (asynchronous); there is no output for them after release.

Test Plan:
- Clean word: in_code=7'b1010101, out_ready=1 -> 2 cycles later out_data=4'b1011, out_err=0, out_pos=0; err_cnt stays 0.
- Single error on d2 (position 5): in_code=7'b1010001 -> out_data=4'b1011, out_err=1, out_pos=5, err_cnt=1. Parity error on p1: 7'b0010101 -> out_data=4'b1011, out_pos=1.
- Exhaustive sweep: all 16 data values x 8 error patterns (none, each position 1..7) at back-to-back valid -> data always recovered, out_pos equals injected position, err_cnt=112.
- Backpressure: out_ready=0 for 5 cycles while streaming 0x0,0x1,0x2 encoded:
  - in_ready drops after 2 words accepted.
  - out_* stable during the stall.
  - After release, outputs appear in order 0x0,0x1,0x2 with none lost.
- Counter edge cases:
  - CNT_W=2: 5 corrected words -> err_cnt=3, saturated.
  - clr_cnt asserted on the same cycle as a counted transfer -> err_cnt=0.
- Reset mid-operation: rst pulsed asynchronously between edges with 2 words in flight -> out_valid=0 and err_cnt=0 immediately; the next word after release decodes with 2-cycle latency.

Source files
------------

// File: rtl/hamming74_decoder_pipe.sv
// Streaming Hamming(7,4) single-error-correcting decoder: two-stage valid/ready
// pipeline (syndrome, then correction) with a saturating corrected-word counter.
module hamming74_decoder_pipe #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       in_code,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       out_data,
    output logic             out_err,
    output logic [2:0]       out_pos,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // code[7-k] carries Hamming position k; each syndrome bit covers the positions with that index bit set.
    function automatic logic [2:0] calc_syn(input logic [6:0] code);
        logic s1, s2, s3;
        s1 = code[6] ^ code[4] ^ code[2] ^ code[0];
        s2 = code[5] ^ code[4] ^ code[1] ^ code[0];
        s3 = code[3] ^ code[2] ^ code[1] ^ code[0];
        return {s3, s2, s1};
    endfunction

    // Flips the bit named by the syndrome, then picks d1..d4 from positions 3,5,6,7.
    function automatic logic [3:0] correct_data(input logic [6:0] code, input logic [2:0] syn);
        logic [6:0] fixed;
        fixed = code;
        if (syn != 3'd0) begin
            fixed[3'd7 - syn] = ~fixed[3'd7 - syn];
        end
        return {fixed[0], fixed[1], fixed[2], fixed[4]};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    logic             vld_p1;
    logic [6:0]       code_p1;
    logic [2:0]       syn_p1;
    logic             vld_p2;
    logic [3:0]       data_p2;
    logic             err_p2;
    logic [2:0]       pos_p2;
    logic [CNT_W-1:0] cnt_q;
    logic             s2_free;
    logic             s1_adv;
    logic             in_fire;

    assign s2_free  = !vld_p2 || out_ready;
    assign s1_adv   = vld_p1 && s2_free;
    assign in_ready = !vld_p1 || s1_adv;
    assign in_fire  = in_valid && in_ready;

    // ---- stage 1: capture codeword and syndrome ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (in_fire) begin
            vld_p1 <= 1'b1;
        end else if (s1_adv) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            code_p1 <= in_code;
            syn_p1  <= calc_syn(in_code);
        end
    end

    // ---- stage 2: corrected data and error report ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            data_p2 <= 4'd0;
            err_p2  <= 1'b0;
            pos_p2  <= 3'd0;
        end else if (s1_adv) begin
            vld_p2  <= 1'b1;
            data_p2 <= correct_data(code_p1, syn_p1);
            err_p2  <= (syn_p1 != 3'd0);
            pos_p2  <= syn_p1;
        end else if (out_ready) begin
            vld_p2  <= 1'b0;
        end
    end

    // ---- output side: count corrected words as they leave ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_cnt) begin
            cnt_q <= '0;
        end else if (vld_p2 && out_ready && err_p2) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    assign out_valid = vld_p2;
    assign out_data  = data_p2;
    assign out_err   = err_p2;
    assign out_pos   = pos_p2;
    assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_hamming74_decoder_pipe.sv
// Bench for hamming74_decoder_pipe: directed vectors, multi-cycle corner cases and
// randomized traffic scored against a position-based Hamming reference model.
module tb_hamming74_decoder_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] in_code;
    logic       in_valid, in_ready, in_ready_s;
    logic [3:0] out_data, out_data_s;
    logic       out_err, out_err_s;
    logic [2:0] out_pos, out_pos_s;
    logic       out_valid, out_valid_s;
    logic       out_ready, clr_cnt;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt_s;

    always #5 clk = ~clk;

    hamming74_decoder_pipe #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_code(in_code), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_err(out_err), .out_pos(out_pos), .out_valid(out_valid),
        .out_ready(out_ready), .clr_cnt(clr_cnt), .err_cnt(err_cnt)
    );

    hamming74_decoder_pipe #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_code(in_code), .in_valid(in_valid), .in_ready(in_ready_s),
        .out_data(out_data_s), .out_err(out_err_s), .out_pos(out_pos_s), .out_valid(out_valid_s),
        .out_ready(out_ready), .clr_cnt(clr_cnt), .err_cnt(err_cnt_s)
    );

    typedef struct packed {
        logic [3:0] data;
        logic       err;
        logic [2:0] pos;
    } res_t;

    typedef struct {
        logic [6:0] code;
        logic [3:0] data;
        logic       err;
        logic [2:0] pos;
        int         cum;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t q[$];
    int   exp_cnt   = 0;
    int   exp_cnt_s = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference encoder: data at positions 3,5,6,7; parity at 2^i covers positions with bit i set.
    function automatic logic [6:0] enc(input logic [3:0] d);
        bit         pos [8];
        logic [6:0] c;
        for (int k = 0; k < 8; k++) pos[k] = 1'b0;
        pos[3] = d[0]; pos[5] = d[1]; pos[6] = d[2]; pos[7] = d[3];
        for (int p = 1; p < 8; p = p * 2) begin
            bit x;
            x = 1'b0;
            for (int j = 1; j < 8; j++) if (j != p && (j & p) != 0) x ^= pos[j];
            pos[p] = x;
        end
        for (int k = 1; k < 8; k++) c[7-k] = pos[k];
        return c;
    endfunction

    function automatic logic [6:0] flip(input logic [6:0] c, input int k);
        logic [6:0] r;
        r = c;
        if (k >= 1 && k <= 7) r[7-k] = ~r[7-k];
        return r;
    endfunction

    // Reference decoder: syndrome is the XOR of the indices of all set positions.
    function automatic res_t model_dec(input logic [6:0] c);
        int         syn;
        logic [6:0] f;
        res_t       r;
        syn = 0;
        for (int k = 1; k < 8; k++) if (c[7-k]) syn = syn ^ k;
        f = flip(c, syn);
        r.data = {f[7-7], f[7-6], f[7-5], f[7-3]};
        r.err  = (syn != 0);
        r.pos  = syn[2:0];
        return r;
    endfunction

    // Scoreboard: handshakes are judged at the falling edge, ahead of the edge that commits them.
    always @(negedge clk) begin : monitor
        logic hs_err;
        res_t r;
        if (!rst) begin
            hs_err = 1'b0;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("stream_unexpected", {out_data, out_err, out_pos}, 32'hFFFF_FFFF);
                end else begin
                    r = q.pop_front();
                    check("stream", {out_data, out_err, out_pos}, r);
                    check("stream_cnt2", {out_data_s, out_err_s, out_pos_s, out_valid_s}, {r, 1'b1});
                    hs_err = r.err;
                end
            end
            if (clr_cnt) begin
                exp_cnt   = 0;
                exp_cnt_s = 0;
            end else if (hs_err) begin
                if (exp_cnt < 255) exp_cnt++;
                if (exp_cnt_s < 3) exp_cnt_s++;
            end
            if (in_valid && in_ready) q.push_back(model_dec(in_code));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one word and waits for acceptance; leaves in_valid asserted for back-to-back use.
    task automatic send(input logic [6:0] code);
        logic ok;
        int   n;
        in_code  = code;
        in_valid = 1'b1;
        n = 0;
        do begin
            #1;
            ok = in_ready;
            tick();
            n++;
        end while (!ok && n < 200);
        check("send_accept", ok, 1'b1);
    endtask

    task automatic drain();
        int n;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 100) begin
            tick();
            n++;
        end
        check("drain_empty", q.size(), 0);
    endtask

    vec_t tbl[7];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_code = '0; out_ready = 1'b1; clr_cnt = 1'b0;

        tbl[0] = '{7'b1010101, 4'b1011, 1'b0, 3'd0, 0};
        tbl[1] = '{7'b1010001, 4'b1011, 1'b1, 3'd5, 1};
        tbl[2] = '{7'b0010101, 4'b1011, 1'b1, 3'd1, 2};
        tbl[3] = '{7'b0000001, 4'b0000, 1'b1, 3'd7, 3};
        tbl[4] = '{7'b1110111, 4'b1111, 1'b1, 3'd4, 4};
        tbl[5] = '{7'b0110101, 4'b1010, 1'b1, 3'd3, 5};  // double error: miscorrected by design
        tbl[6] = '{7'b0000000, 4'b0000, 1'b0, 3'd0, 5};

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 4'd0);
        check("rst_out_err", out_err, 1'b0);
        check("rst_out_pos", out_pos, 3'd0);
        check("rst_err_cnt", err_cnt, 8'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b1);

        // Directed vectors, one word at a time, checking exact 2-cycle latency
        for (int i = 0; i < 7; i++) begin
            tick();
            in_code  = tbl[i].code;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            check("vec_lat_early", out_valid, 1'b0);
            tick();
            check("vec_out_valid", out_valid, 1'b1);
            check("vec_out", {out_data, out_err, out_pos}, {tbl[i].data, tbl[i].err, tbl[i].pos});
            tick();
            check("vec_vld_clear", out_valid, 1'b0);
            check("vec_err_cnt", err_cnt, tbl[i].cum);
        end

        // Exhaustive sweep, back-to-back
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("clr_err_cnt", err_cnt, 8'd0);
        for (int d = 0; d < 16; d++)
            for (int e = 0; e < 8; e++)
                send(flip(enc(d[3:0]), e));
        drain();
        check("sweep_err_cnt", err_cnt, 8'd112);
        check("sweep_err_cnt_model", err_cnt, exp_cnt);
        check("sweep_cnt2_sat", err_cnt_s, 2'd3);

        // Saturation of the narrow counter
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            send(flip(enc(k[3:0]), k));
            drain();
            check("sat_cnt2", err_cnt_s, (k < 3) ? k : 3);
            check("sat_cnt8", err_cnt, k);
        end

        // Clear wins over a counted transfer on the same edge
        in_code  = flip(enc(4'h6), 2);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("clr_pri_pending", {out_valid, out_err}, 2'b11);
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        check("clr_pri_cnt8", err_cnt, 8'd0);
        check("clr_pri_cnt2", err_cnt_s, 2'd0);
        check("clr_pri_consumed", out_valid, 1'b0);

        // Backpressure: stall the output while streaming 0x0, 0x1, 0x2
        out_ready = 1'b0;
        in_code   = enc(4'h0);
        in_valid  = 1'b1;
        #1;
        check("bp_rdy_w0", in_ready, 1'b1);
        tick();
        in_code = enc(4'h1);
        #1;
        check("bp_rdy_w1", in_ready, 1'b1);
        tick();
        in_code = enc(4'h2);
        #1;
        check("bp_rdy_drop", in_ready, 1'b0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("bp_stall_hold", {out_valid, out_data, out_err, out_pos, in_ready}, {1'b1, 4'h0, 1'b0, 3'd0, 1'b0});
        end
        out_ready = 1'b1;
        #1;
        check("bp_rdy_release", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check("bp_order_1", {out_valid, out_data}, {1'b1, 4'h1});
        tick();
        check("bp_order_2", {out_valid, out_data}, {1'b1, 4'h2});
        tick();
        check("bp_done", out_valid, 1'b0);
        check("bp_queue", q.size(), 0);

        // Asynchronous reset with two words in flight
        send(flip(enc(4'h3), 6));
        drain();
        check("pre_rst_cnt", err_cnt, 8'd1);
        out_ready = 1'b0;
        send(flip(enc(4'h5), 2));
        send(enc(4'h9));
        in_valid = 1'b0;
        check("pre_rst_full", {out_valid, in_ready}, 2'b10);
        #1;
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_err_cnt", err_cnt, 8'd0);
        check("arst_in_ready", in_ready, 1'b1);
        q.delete();
        exp_cnt   = 0;
        exp_cnt_s = 0;
        rst       = 1'b0;
        out_ready = 1'b1;
        tick();
        in_code  = flip(enc(4'hC), 7);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("post_rst_lat_early", out_valid, 1'b0);
        tick();
        check("post_rst_out", {out_valid, out_data, out_err, out_pos}, {1'b1, 4'hC, 1'b1, 3'd7});
        drain();
        check("post_rst_cnt", err_cnt, 8'd1);

        // Randomized traffic with random backpressure and occasional clears
        for (int c = 0; c < 3000; c++) begin
            int e, a;
            logic [6:0] w;
            w = enc($urandom_range(0, 15));
            e = $urandom_range(0, 9);
            if (e <= 7) begin
                w = flip(w, e);
            end else begin
                a = $urandom_range(1, 7);
                w = flip(flip(w, a), (a % 7) + 1);
            end
            in_code   = w;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            clr_cnt   = ($urandom_range(0, 99) == 0);
            tick();
        end
        clr_cnt = 1'b0;
        drain();
        check("rand_err_cnt", err_cnt, exp_cnt);
        check("rand_err_cnt2", err_cnt_s, exp_cnt_s);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
